// File: rtl/keypad_digit_loader_pkg.sv
// Shared definitions for the keypad digit loader: FSM states, entry limits and key encoding.
package keypad_digit_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_LOAD,
        ST_HOLD,
        ST_RELEASE_DB
    } state_t;

    localparam int MAX_DIGITS = 3;
    localparam int TENS_MAX   = 5;
    localparam logic [3:0] NO_KEY = 4'hF;

    // Returns {valid, code}; anything other than exactly one key line is "no key".
    function automatic logic [4:0] encode_key(input logic [9:0] keys);
        logic [3:0] code;
        int         hits;
        code = NO_KEY;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) begin
                hits++;
                code = 4'(i);
            end
        end
        return (hits == 1) ? {1'b1, code} : {1'b0, NO_KEY};
    endfunction

endpackage

// File: rtl/keypad_digit_loader_key_debounce.sv
// Two-flop synchronizer for the raw key lines followed by the one-hot to BCD encoder.
module key_debounce
    import keypad_digit_loader_pkg::*;
(
    input  logic       clock,
    input  logic       clr,
    input  logic [9:0] keypad,
    output logic [3:0] code,
    output logic       valid
);

    logic [9:0] sync1;
    logic [9:0] sync2;

    always_ff @(posedge clock) begin
        if (clr) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keypad;
            sync2 <= sync1;
        end
    end

    assign {valid, code} = encode_key(sync2);

endmodule

// File: rtl/keypad_digit_loader.sv
// Keypad front end for the min/sec timer: debounced presses become BCD digits plus a loadn strobe.
//
// state         | meaning
// ST_IDLE       | waiting for a valid key while the timer is not busy
// ST_PRESS_DB   | candidate key must stay stable for DEBOUNCE_CYCLES cycles
// ST_LOAD       | loadn low for one cycle, data holds the new digit
// ST_HOLD       | key still down, waiting for it to be released
// ST_RELEASE_DB | no-key must persist DEBOUNCE_CYCLES cycles before IDLE
module keypad_digit_loader
    import keypad_digit_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       clr,
    input  logic [9:0] keypad,
    input  logic       busy,
    input  logic       entry_clr,
    output logic [3:0] data,
    output logic       loadn,
    output logic [1:0] digit_count,
    output logic       err,
    output logic       ready
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    state_t           state;
    logic [3:0]       key_code;
    logic             key_valid;
    logic [3:0]       cand;
    logic [3:0]       last_digit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             db_done;
    logic             reject;

    key_debounce u_key_debounce (
        .clock  (clock),
        .clr    (clr),
        .keypad (keypad),
        .code   (key_code),
        .valid  (key_valid)
    );

    assign cnt_inc = cnt + CNT_W'(1);
    assign db_done = (cnt_inc == CNT_W'(DEBOUNCE_CYCLES));

    // The previous digit moves into tens-of-seconds, so it must not exceed 5.
    assign reject = (digit_count == 2'(MAX_DIGITS)) ||
                    ((digit_count != 2'd0) && (last_digit > 4'(TENS_MAX)));

    assign ready = (state == ST_IDLE) && (digit_count != 2'(MAX_DIGITS)) && !busy;

    always_ff @(posedge clock) begin
        if (clr) begin
            state       <= ST_IDLE;
            cand        <= '0;
            cnt         <= '0;
            data        <= '0;
            loadn       <= 1'b1;
            digit_count <= '0;
            last_digit  <= '0;
            err         <= 1'b0;
        end else begin
            loadn <= 1'b1;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_valid && !busy) begin
                        cand  <= key_code;
                        cnt   <= '0;
                        state <= ST_PRESS_DB;
                    end
                end
                ST_PRESS_DB: begin
                    if (!key_valid || (key_code != cand) || busy) begin
                        state <= ST_IDLE;
                    end else if (db_done) begin
                        if (reject) begin
                            err   <= 1'b1;
                            state <= ST_HOLD;
                        end else begin
                            loadn       <= 1'b0;
                            data        <= cand;
                            last_digit  <= cand;
                            digit_count <= digit_count + 2'd1;
                            state       <= ST_LOAD;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_LOAD: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!key_valid) begin
                        cnt   <= '0;
                        state <= ST_RELEASE_DB;
                    end
                end
                ST_RELEASE_DB: begin
                    if (key_valid) begin
                        state <= ST_HOLD;
                    end else if (db_done) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A new entry wins over a coincident load's count increment.
            if (entry_clr) begin
                digit_count <= '0;
                last_digit  <= '0;
            end
        end
    end

endmodule
